// File: rtl/seq_mult_6x6_pkg.sv
// Shared definitions for the sequential 6x6 multiplier: widths, FSM
// encoding and the slice-selection / alignment helpers.
package seq_mult_6x6_pkg;

    // Operand width, fixed by the 6x2 array multiplier.
    localparam int OPW    = 6;
    // Bits of the multiplier operand consumed per cycle.
    localparam int SLICE  = 2;
    // Slices per operation.
    localparam int NSLICE = OPW / SLICE;
    // Width of one partial product (6x2 -> 8 bits).
    localparam int PPW    = OPW + SLICE;
    // Accumulator / product width; 63*63 = 3969 always fits.
    localparam int ACCW   = 2 * OPW;
    // Width of the slice counter.
    localparam int KW     = 2;

    // Index of the final slice; reaching it closes the operation.
    localparam logic [KW-1:0] K_LAST = 2'd2;

    // Controller states. The unused code 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Pick the 2-bit slice of the multiplier addressed by the counter.
    function automatic logic [SLICE-1:0] slice_sel(
        input logic [OPW-1:0] b,
        input logic [KW-1:0]  k
    );
        logic [SLICE-1:0] s;
        case (k)
            2'd0:    s = b[1:0];
            2'd1:    s = b[3:2];
            2'd2:    s = b[5:4];
            default: s = 2'b00;
        endcase
        return s;
    endfunction

    // Place a partial product at bit position 2k inside the accumulator.
    function automatic logic [ACCW-1:0] align_pp(
        input logic [PPW-1:0] pp,
        input logic [KW-1:0]  k
    );
        logic [ACCW-1:0] r;
        case (k)
            2'd0:    r = {4'b0000, pp};
            2'd1:    r = {2'b00, pp, 2'b00};
            2'd2:    r = {pp, 4'b0000};
            default: r = 12'h000;
        endcase
        return r;
    endfunction

endpackage : seq_mult_6x6_pkg

// File: rtl/seq_mult_6x6_multiplier.sv
// Combinational 6x2 unsigned array multiplier. Two AND rows (one per
// multiplier bit) are shifted and summed into an 8-bit partial product.
module seq_mult_6x6_multiplier
    import seq_mult_6x6_pkg::*;
(
    input  logic [OPW-1:0]   a_i,
    input  logic [SLICE-1:0] b_i,
    output logic [PPW-1:0]   pp_o
);

    logic [PPW-1:0] row0_s;
    logic [PPW-1:0] row1_s;

    // Form the two AND rows and add them; max 63*3 = 189 fits in 8 bits.
    always_comb begin
        row0_s = {2'b00, (a_i & {OPW{b_i[0]}})};
        row1_s = {1'b0, (a_i & {OPW{b_i[1]}}), 1'b0};
        pp_o   = row0_s + row1_s;
    end

endmodule : seq_mult_6x6_multiplier

// File: rtl/seq_mult_6x6.sv
// Sequential 6x6 unsigned multiplier. Operands are captured on an accepted
// start; one 2-bit slice of in2 per cycle goes through the 6x2 array and
// the shifted partial product is added into a 12-bit accumulator. After the
// third slice the sum is loaded into product and done pulses for one cycle.
// A start seen in the DONE cycle is accepted immediately (back-to-back),
// giving one result every four cycles.
module seq_mult_6x6
    import seq_mult_6x6_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  in1,
    input  logic [OPW-1:0]  in2,
    output logic            busy,
    output logic            done,
    output logic [ACCW-1:0] product
);

    state_e           state_q,   state_d;
    logic [OPW-1:0]   a_q,       a_d;
    logic [OPW-1:0]   b_q,       b_d;
    logic [ACCW-1:0]  acc_q,     acc_d;
    logic [KW-1:0]    k_q,       k_d;
    logic [ACCW-1:0]  product_q, product_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [SLICE-1:0] slice_s;
    logic [PPW-1:0]   pp_s;
    logic [ACCW-1:0]  acc_sum_s;

    // Select the multiplier slice addressed by the counter for the array.
    always_comb begin
        slice_s = slice_sel(b_q, k_q);
    end

    seq_mult_6x6_multiplier u_mult (
        .a_i  (a_q),
        .b_i  (slice_s),
        .pp_o (pp_s)
    );

    // Running sum including this cycle's aligned partial product.
    always_comb begin
        acc_sum_s = acc_q + align_pp(pp_s, k_q);
    end

    // Next-state, datapath updates and registered output flags.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        k_d       = k_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    acc_d   = 12'h000;
                    k_d     = 2'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // start is deliberately ignored here; operands stay frozen.
                acc_d = acc_sum_s;
                if (k_q == K_LAST) begin
                    product_d = acc_sum_s;
                    k_d       = 2'd0;
                    state_d   = DONE;
                end else begin
                    k_d       = k_q + 2'd1;
                    state_d   = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    acc_d   = 12'h000;
                    k_d     = 2'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = 12'h000;
                k_d     = 2'd0;
            end
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 6'd0;
            b_q       <= 6'd0;
            acc_q     <= 12'h000;
            k_q       <= 2'd0;
            product_q <= 12'h000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_mult_6x6

// File: tb/tb_seq_mult_6x6.sv
// Scoreboard bench for seq_mult_6x6: the stimulus side queues the
// arithmetic product of every operation it expects to complete, and a
// monitor pops and compares on every done pulse.
module tb_seq_mult_6x6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  in1;
    logic [5:0]  in2;
    logic        busy;
    logic        done;
    logic [11:0] product;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int unsigned exp_q[$];
    int unsigned mon_exp;

    always #5 clk = ~clk;

    seq_mult_6x6 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Reference model: plain unsigned multiplication.
    function automatic int unsigned ref_mul(input int unsigned x, input int unsigned y);
        return x * y;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("product", product, mon_exp);
            end
        end
    end

    // Present operands for one cycle (called at a negedge), then scramble inputs.
    task automatic issue(input int unsigned x, input int unsigned y, input bit expect_res);
        start = 1'b1;
        in1   = 6'(x);
        in2   = 6'(y);
        if (expect_res) exp_q.push_back(ref_mul(x, y));
        @(negedge clk);
        start = 1'b0;
        in1   = 6'($urandom);
        in2   = 6'($urandom);
    endtask

    // Count negedges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 12);
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int bcnt;

        // 1. Reset with start held high.
        rst = 1'b1; start = 1'b1; in1 = 6'd63; in2 = 6'd63;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_idle_busy", busy, 0);

        // 2. 63*63 latency and busy window.
        issue(63, 63, 1);
        bcnt = (busy === 1'b1) ? 1 : 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (done !== 1'b1 && busy === 1'b1) bcnt++;
        end while (done !== 1'b1 && n < 12);
        check("busy_cycles", bcnt, 3);
        check("done_latency", n, 3);
        check("busy_at_done", busy, 0);

        // 3. Zero and single-bit slice positions.
        issue(0, 45, 1);  wait_done(n); check("lat_0x45", n, 3);
        issue(1, 1, 1);   wait_done(n); check("lat_1x1", n, 3);
        issue(42, 1, 1);  wait_done(n); check("lat_42x1", n, 3);
        issue(63, 16, 1); wait_done(n); check("lat_63x16", n, 3);
        repeat (2) @(negedge clk);

        // 4. start held high: restart in the DONE cycle with new operands.
        start = 1'b1; in1 = 6'd5; in2 = 6'd7;
        exp_q.push_back(ref_mul(5, 7));
        wait_done(n);
        check("held_first_latency", n, 4);
        in1 = 6'd21; in2 = 6'd10;
        exp_q.push_back(ref_mul(21, 10));
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(n2);
        check("b2b_interval", n2 + 1, 4);
        repeat (2) @(negedge clk);

        // 5. start during CALC is ignored.
        issue(9, 9, 1);
        start = 1'b1; in1 = 6'd60; in2 = 6'd60;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ignore_latency", n, 2);
        @(negedge clk);
        check("ignore_busy_after", busy, 0);
        check("ignore_done_after", done, 0);
        repeat (6) @(negedge clk);

        // 6. Reset in the middle of an operation.
        issue(33, 17, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", done, 0);
        issue(12, 13, 1); wait_done(n); check("lat_12x13", n, 3);

        // Full operand sweep, back-to-back.
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                issue(i, j, 1);
                wait_done(n);
                if (n != 3) check("sweep_latency", n, 3);
            end
        end

        // Random operands with random idle gaps.
        for (int r = 0; r < 300; r++) begin
            issue($urandom_range(63), $urandom_range(63), 1);
            wait_done(n);
            check("rand_latency", n, 3);
            if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_seq_mult_6x6
